// File: rtl/display_source_scheduler.sv
`timescale 1ns/1ps
// Purpose: selects which task image (P/Q/R) feeds the OLED, switching only at frame boundaries with a blanking interval.
// Latency: display_data is registered, 1 clk behind p_data/q_data/r_data and the state decision.
// Backpressure: none; the pixel stream is free-running and the OLED driver always consumes display_data.
module display_source_scheduler #(
  parameter int          STABLE_CYCLES = 100000,
  parameter int          BLANK_FRAMES  = 1,
  parameter int          DWELL_FRAMES  = 120,
  parameter logic [15:0] BLANK_COLOUR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] pixel_index,
  input  logic [2:0]  sel_req,
  input  logic        auto_en,
  input  logic [15:0] p_data,
  input  logic [15:0] q_data,
  input  logic [15:0] r_data,
  output logic [15:0] display_data,
  output logic [1:0]  active_src,
  output logic        busy
);

  typedef enum logic [1:0] {
    SHOW    = 2'd0,
    PENDING = 2'd1,
    BLANK   = 2'd2
  } state_t;

  localparam logic [1:0] SRC_P    = 2'd0;
  localparam logic [1:0] SRC_Q    = 2'd1;
  localparam logic [1:0] SRC_R    = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int DW = (DWELL_FRAMES  > 1) ? $clog2(DWELL_FRAMES)  : 1;
  localparam int BW = (BLANK_FRAMES  > 1) ? $clog2(BLANK_FRAMES)  : 1;

  localparam logic [SW-1:0] STAB_MAX   = SW'((STABLE_CYCLES > 0) ? STABLE_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DWELL_MAX  = DW'((DWELL_FRAMES  > 0) ? DWELL_FRAMES  - 1 : 0);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_FRAMES  > 0) ? BLANK_FRAMES  - 1 : 0);

  // With no blank frames a source change lands straight back in SHOW.
  localparam state_t AFTER_SWITCH = (BLANK_FRAMES > 0) ? BLANK : SHOW;

  state_t        state;
  state_t        state_n;
  logic [12:0]   pix_q;
  logic [1:0]    tgt_q;
  logic [1:0]    pend_src;
  logic [1:0]    pend_n;
  logic [1:0]    active_n;
  logic [SW-1:0] stab_cnt;
  logic [DW-1:0] dwell_cnt;
  logic [DW-1:0] dwell_n;
  logic [BW-1:0] blank_cnt;
  logic [BW-1:0] blank_n;
  logic [1:0]    target;
  logic [1:0]    next_src;
  logic          frame_start;
  logic          qualified;
  logic [15:0]   pixel_n;

  // Manual target: highest requested switch wins, NONE when no switch is up.
  always_comb begin
    target = SRC_NONE;
    if (sel_req[2])      target = SRC_R;
    else if (sel_req[1]) target = SRC_Q;
    else if (sel_req[0]) target = SRC_P;
  end

  // Frame boundary is the wrap to pixel 0; the idle 0 straight out of reset does not count.
  always_comb begin
    frame_start = (pixel_index == 13'd0) && (pix_q != 13'd0);
    qualified   = (stab_cnt == STAB_MAX) && (target == tgt_q);
  end

  // Auto rotation order P -> Q -> R -> P; NONE starts the rotation at P.
  always_comb begin
    next_src = SRC_P;
    case (active_src)
      SRC_P:   next_src = SRC_Q;
      SRC_Q:   next_src = SRC_R;
      default: next_src = SRC_P;
    endcase
  end

  // Next-state decision for the scheduler FSM and its counters.
  always_comb begin
    state_n  = state;
    active_n = active_src;
    pend_n   = pend_src;
    blank_n  = blank_cnt;
    dwell_n  = dwell_cnt;

    // Dwell only advances in auto mode, and saturates so it never wraps past the switch point.
    if (!auto_en)
      dwell_n = '0;
    else if (frame_start && (dwell_cnt != DWELL_MAX))
      dwell_n = dwell_cnt + 1'b1;

    case (state)
      SHOW: begin
        if (auto_en) begin
          if (frame_start && (dwell_cnt == DWELL_MAX)) begin
            active_n = next_src;
            dwell_n  = '0;
            blank_n  = '0;
            state_n  = AFTER_SWITCH;
          end
        end else if (qualified && (target != active_src)) begin
          pend_n  = target;
          state_n = PENDING;
        end
      end
      PENDING: begin
        // Aborts take priority over a frame boundary in the same cycle.
        if (auto_en || (target != pend_src)) begin
          state_n = SHOW;
        end else if (frame_start) begin
          active_n = pend_src;
          blank_n  = '0;
          dwell_n  = '0;
          state_n  = AFTER_SWITCH;
        end
      end
      BLANK: begin
        if (frame_start) begin
          if (blank_cnt == BLANK_LAST)
            state_n = SHOW;
          else
            blank_n = blank_cnt + 1'b1;
        end
      end
      default: state_n = SHOW;
    endcase
  end

  // Output pixel follows the post-decision state so a switch is visible on the same edge.
  always_comb begin
    pixel_n = 16'h0000;
    if (state_n == BLANK) begin
      pixel_n = BLANK_COLOUR;
    end else begin
      case (active_n)
        SRC_P:   pixel_n = p_data;
        SRC_Q:   pixel_n = q_data;
        SRC_R:   pixel_n = r_data;
        default: pixel_n = 16'h0000;
      endcase
    end
  end

  // All scheduler state, the stability filter and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SHOW;
      pix_q        <= '0;
      tgt_q        <= SRC_P;
      stab_cnt     <= '0;
      pend_src     <= SRC_NONE;
      dwell_cnt    <= '0;
      blank_cnt    <= '0;
      active_src   <= SRC_NONE;
      display_data <= 16'h0000;
      busy         <= 1'b0;
    end else begin
      pix_q <= pixel_index;
      tgt_q <= target;
      if (target != tgt_q)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 1'b1;
      state        <= state_n;
      pend_src     <= pend_n;
      dwell_cnt    <= dwell_n;
      blank_cnt    <= blank_n;
      active_src   <= active_n;
      display_data <= pixel_n;
      busy         <= (state_n != SHOW);
    end
  end

endmodule

// File: tb/tb_display_source_scheduler.sv
`timescale 1ns/1ps
// Directed bench for display_source_scheduler with short stability/dwell settings.
// Inputs change 1 ns after each rising edge, outputs are sampled at that same point.
// No flow control: the pixel stream is driven cycle by cycle from the sequence below.
module tb_display_source_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] pixel_index;
  logic [2:0]  sel_req;
  logic        auto_en;
  logic [15:0] p_data;
  logic [15:0] q_data;
  logic [15:0] r_data;
  logic [15:0] display_data;
  logic [1:0]  active_src;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  display_source_scheduler #(
    .STABLE_CYCLES (4),
    .BLANK_FRAMES  (1),
    .DWELL_FRAMES  (2),
    .BLANK_COLOUR  (16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_index  (pixel_index),
    .sel_req      (sel_req),
    .auto_en      (auto_en),
    .p_data       (p_data),
    .q_data       (q_data),
    .r_data       (r_data),
    .display_data (display_data),
    .active_src   (active_src),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Last pixel of a frame, then the wrap to 0 (the frame_start edge), then mid-frame again.
  task automatic wrap();
    pixel_index = 13'd6143;
    step(1);
    pixel_index = 13'd0;
    step(1);
    pixel_index = 13'd100;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    sel_req     = 3'b001;
    auto_en     = 1'b0;
    pixel_index = 13'd0;
    p_data      = 16'hF800;
    q_data      = 16'h07E0;
    r_data      = 16'h001F;
    step(2);
    chk("rst_display", display_data, 16'h0000);
    chk("rst_active",  {14'd0, active_src}, 16'd3);
    chk("rst_busy",    {15'd0, busy}, 16'd0);
    rst         = 1'b0;
    pixel_index = 13'd100;

    // Stability: three edges to saturate, the fourth moves to PENDING.
    step(3);
    chk("pre_qual_busy", {15'd0, busy}, 16'd0);
    step(1);
    chk("pending_busy",   {15'd0, busy}, 16'd1);
    chk("pending_active", {14'd0, active_src}, 16'd3);
    chk("pending_disp",   display_data, 16'h0000);
    step(4);
    wrap();
    chk("sw_p_active", {14'd0, active_src}, 16'd0);
    chk("sw_p_busy",   {15'd0, busy}, 16'd1);
    chk("sw_p_blank",  display_data, 16'h0000);
    step(3);
    chk("blank_hold_busy", {15'd0, busy}, 16'd1);
    chk("blank_hold_disp", display_data, 16'h0000);
    wrap();
    chk("show_p_busy", {15'd0, busy}, 16'd0);
    chk("show_p_disp", display_data, 16'hF800);
    p_data = 16'h1234;
    step(1);
    chk("p_follow", display_data, 16'h1234);

    // Multiple switches: R has priority; old source stays visible while pending.
    sel_req = 3'b111;
    step(4);
    chk("r_prequal_busy", {15'd0, busy}, 16'd0);
    step(1);
    chk("r_pending_busy", {15'd0, busy}, 16'd1);
    chk("r_pending_disp", display_data, 16'h1234);
    chk("r_pending_act",  {14'd0, active_src}, 16'd0);
    wrap();
    chk("sw_r_active", {14'd0, active_src}, 16'd2);
    chk("sw_r_blank",  display_data, 16'h0000);
    wrap();
    chk("show_r_busy", {15'd0, busy}, 16'd0);
    chk("show_r_disp", display_data, 16'h001F);

    // Return to P for the glitch test.
    p_data  = 16'hF800;
    sel_req = 3'b001;
    step(5);
    chk("back_p_pending", {15'd0, busy}, 16'd1);
    wrap();
    wrap();
    chk("back_p_active", {14'd0, active_src}, 16'd0);
    chk("back_p_busy",   {15'd0, busy}, 16'd0);

    // Two-cycle glitch on Q never qualifies.
    sel_req = 3'b010;
    step(2);
    sel_req = 3'b001;
    step(6);
    chk("glitch_busy",   {15'd0, busy}, 16'd0);
    chk("glitch_active", {14'd0, active_src}, 16'd0);

    // Abort on target change beats a frame_start in the same cycle.
    sel_req = 3'b010;
    step(5);
    chk("abort_pre_busy", {15'd0, busy}, 16'd1);
    pixel_index = 13'd6143;
    step(1);
    sel_req     = 3'b001;
    pixel_index = 13'd0;
    step(1);
    pixel_index = 13'd100;
    chk("abort_busy",   {15'd0, busy}, 16'd0);
    chk("abort_active", {14'd0, active_src}, 16'd0);
    chk("abort_disp",   display_data, 16'hF800);

    // Auto rotation with a two-frame dwell including the blank frame.
    auto_en = 1'b1;
    wrap();
    chk("auto_dwell1_act",  {14'd0, active_src}, 16'd0);
    chk("auto_dwell1_busy", {15'd0, busy}, 16'd0);
    wrap();
    chk("auto_q_active", {14'd0, active_src}, 16'd1);
    chk("auto_q_busy",   {15'd0, busy}, 16'd1);
    chk("auto_q_blank",  display_data, 16'h0000);
    wrap();
    chk("auto_q_show_busy", {15'd0, busy}, 16'd0);
    chk("auto_q_show_disp", display_data, 16'h07E0);
    wrap();
    chk("auto_r_active", {14'd0, active_src}, 16'd2);
    chk("auto_r_busy",   {15'd0, busy}, 16'd1);
    wrap();
    chk("auto_r_show_disp", display_data, 16'h001F);
    wrap();
    chk("auto_p_active", {14'd0, active_src}, 16'd0);
    chk("auto_p_busy",   {15'd0, busy}, 16'd1);

    // Reset while blanking.
    rst = 1'b1;
    step(1);
    chk("midrst_disp",   display_data, 16'h0000);
    chk("midrst_active", {14'd0, active_src}, 16'd3);
    chk("midrst_busy",   {15'd0, busy}, 16'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
